// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: round-robin sharing of one block-wide memory port between L1 I-cache refills and L1 D-cache refills/write-backs.
module l1_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int BLOCK_W = 128
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_req,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [BLOCK_W-1:0] i_rdata,
    output logic               i_done,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [BLOCK_W-1:0] d_wdata,
    output logic [BLOCK_W-1:0] d_rdata,
    output logic               d_done,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic [BLOCK_W-1:0] mem_rdata,
    input  logic               mem_ready,
    output logic               busy,
    output logic               owner_d
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    state_t               state_q, state_d;
    logic                 own_d_q, own_d_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BLOCK_W-1:0]   wdata_q, wdata_d;
    logic [BLOCK_W-1:0]   i_rdata_q, i_rdata_d;
    logic [BLOCK_W-1:0]   d_rdata_q, d_rdata_d;
    logic                 grant, grant_d;

    // On a tie the port that did not win last time gets the grant.
    assign grant   = (state_q == IDLE) && (i_req || d_req);
    assign grant_d = d_req && (!i_req || !own_d_q);

    always_ff @(posedge clock) begin
        state_q <= reset ? IDLE : state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (grant ? (grant_d ? BUSY_D : BUSY_I) : IDLE) :
                  (state_q == RESP) ? IDLE :
                  (mem_ready ? RESP : state_q);
    end

    always_comb begin
        own_d_d   = grant ? grant_d : own_d_q;
        addr_d    = grant ? (grant_d ? d_addr : i_addr) : addr_q;
        we_d      = grant ? (grant_d && d_we) : we_q;
        wdata_d   = (grant && grant_d) ? d_wdata : wdata_q;
        i_rdata_d = (state_q == BUSY_I && mem_ready) ? mem_rdata : i_rdata_q;
        d_rdata_d = (state_q == BUSY_D && mem_ready && !we_q) ? mem_rdata : d_rdata_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            own_d_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            own_d_q   <= own_d_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // The memory bus is driven to zero whenever no transfer is in flight.
    always_comb begin
        mem_req   = (state_q == BUSY_I) || (state_q == BUSY_D);
        mem_we    = (state_q == BUSY_D) && we_q;
        mem_addr  = mem_req ? addr_q : '0;
        mem_wdata = (state_q == BUSY_D) ? wdata_q : '0;
        i_done    = (state_q == RESP) && !own_d_q;
        d_done    = (state_q == RESP) && own_d_q;
        busy      = state_q != IDLE;
        owner_d   = own_d_q;
        i_rdata   = i_rdata_q;
        d_rdata   = d_rdata_q;
    end
endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb_l1_mem_arbiter: scoreboard bench; expected transfers are queued at issue and retired on each done pulse.
module tb_l1_mem_arbiter;
    localparam int AW = 32;
    localparam int BW = 128;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [BW-1:0] d_wdata = '0, mem_rdata = '0;
    logic [BW-1:0] i_rdata, d_rdata, mem_wdata;
    logic          i_done, d_done, mem_req, mem_we, busy, owner_d;
    logic [AW-1:0] mem_addr;

    always #5 clock = ~clock;

    l1_mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .owner_d(owner_d)
    );

    typedef struct {
        logic          d;
        logic          we;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
        logic [BW-1:0] ret;
        logic [BW-1:0] exp;
    } txn_t;

    txn_t          sb[$];
    int            vectors = 0, miscompares = 0;
    logic          own_m = 1'b0;
    logic [BW-1:0] m_i = '0, m_d = '0;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle_zero(input string tag);
        chk({tag, ".mem_req"}, BW'(mem_req), '0);
        chk({tag, ".mem_we"}, BW'(mem_we), '0);
        chk({tag, ".mem_addr"}, BW'(mem_addr), '0);
        chk({tag, ".mem_wdata"}, mem_wdata, '0);
        chk({tag, ".dones"}, BW'({i_done, d_done}), '0);
        chk({tag, ".busy"}, BW'(busy), '0);
    endtask

    task automatic do_reset();
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        own_m = 1'b0; m_i = '0; m_d = '0;
        sb.delete();
    endtask

    task automatic push(input logic d, input logic we, input logic [AW-1:0] addr,
                        input logic [BW-1:0] wdata, input logic [BW-1:0] ret);
        txn_t t;
        t.d = d; t.we = we; t.addr = addr; t.wdata = wdata; t.ret = ret;
        t.exp = (d && we) ? m_d : ret;
        if (d) m_d = t.exp; else m_i = t.exp;
        own_m = d;
        sb.push_back(t);
    endtask

    task automatic issue_i(input logic [AW-1:0] addr, input logic [BW-1:0] ret);
        i_req = 1'b1; i_addr = addr;
        push(1'b0, 1'b0, addr, '0, ret);
    endtask

    task automatic issue_d(input logic we, input logic [AW-1:0] addr,
                           input logic [BW-1:0] wdata, input logic [BW-1:0] ret);
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        push(1'b1, we, addr, wdata, ret);
    endtask

    // Plays the memory: answers the front transfer after lat busy cycles.
    task automatic serve(input int lat, input bit poke_addr);
        txn_t e;
        int   n = 0;
        e = sb[0];
        while (!mem_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("grant", BW'(mem_req), BW'(1));
        chk("owner_d", BW'(owner_d), BW'(e.d));
        for (int k = 1; k <= lat; k++) begin
            chk("mem_req", BW'(mem_req), BW'(1));
            chk("busy", BW'(busy), BW'(1));
            chk("mem_addr", BW'(mem_addr), BW'(e.addr));
            chk("mem_we", BW'(mem_we), BW'(e.we));
            chk("early_done", BW'({i_done, d_done}), '0);
            if (e.d) chk("mem_wdata", mem_wdata, e.wdata);
            if (poke_addr && k == 1) d_addr = 32'hFFFF_FFC0;
            mem_ready = (k == lat);
            mem_rdata = (k == lat) ? e.ret : rnd();
            @(negedge clock);
        end
        mem_ready = 1'b0;
        mem_rdata = rnd();
        e = sb.pop_front();
        chk("i_done", BW'(i_done), BW'(!e.d));
        chk("d_done", BW'(d_done), BW'(e.d));
        chk("resp_busy", BW'(busy), BW'(1));
        chk("resp_mem_req", BW'(mem_req), '0);
        if (e.d) begin
            chk("d_rdata", d_rdata, e.exp);
            d_req = 1'b0;
        end else begin
            chk("i_rdata", i_rdata, e.exp);
            i_req = 1'b0;
        end
        @(negedge clock);
        chk("done_low", BW'({i_done, d_done}), '0);
        chk("post_mem_req", BW'(mem_req), '0);
        chk("post_rdata", e.d ? d_rdata : i_rdata, e.exp);
    endtask

    initial begin
        logic [BW-1:0] keep;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            idle_zero("idle");
            chk("idle_owner", BW'(owner_d), '0);
            mem_ready = (c == 5);
            mem_rdata = rnd();
            @(negedge clock);
        end
        mem_ready = 1'b0;
        chk("idle_i_rdata", i_rdata, '0);
        chk("idle_d_rdata", d_rdata, '0);

        issue_i(32'h0000_1040, {16{8'hA5}});
        serve(3, 1'b0);
        issue_d(1'b0, 32'h0000_3000, '0, rnd());
        serve(2, 1'b0);
        issue_d(1'b1, 32'h0000_2000, {8{16'h1234}}, rnd());
        serve(1, 1'b0);
        issue_i(32'h0000_5080, rnd());
        serve(4, 1'b0);

        do_reset();
        i_addr = 32'h0001_0000; d_addr = 32'h0002_0000; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int r = 0; r < 6; r++) begin
            logic w;
            w = !own_m;
            push(w, 1'b0, w ? d_addr : i_addr, d_wdata, rnd());
            serve(1 + r % 2, 1'b0);
            if (w) begin
                d_addr = d_addr + 32'h40; d_req = 1'b1;
            end else begin
                i_addr = i_addr + 32'h40; i_req = 1'b1;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (3) @(negedge clock);

        do_reset();
        issue_d(1'b0, 32'h0000_4000, '0, rnd());
        serve(3, 1'b1);
        keep = d_rdata;
        chk("keep_nonzero", BW'(keep != '0), BW'(1));
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_6000; d_wdata = rnd();
        for (int n = 0; n < 20 && !mem_req; n++) @(negedge clock);
        chk("abort_grant", BW'(mem_req), BW'(1));
        @(negedge clock);
        reset = 1'b1; d_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        mem_ready = 1'b1; mem_rdata = rnd();
        @(negedge clock);
        mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            idle_zero("abort");
            chk("abort_owner", BW'(owner_d), '0);
            chk("abort_d_rdata", d_rdata, '0);
            @(negedge clock);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/l1_mem_arbiter.md
# l1_mem_arbiter

Shares the single main-memory port between the L1 instruction cache (refill reads only) and the L1 data cache (refill reads and dirty write-backs). It sits between both cache controllers and the memory model.
- Arbitrates simultaneous misses round-robin.
- Serialises one block transfer at a time.
- Registers the returned block toward the winning cache with a one-cycle done pulse.

## Interface
Parameters:
- ADDR_W, 32, byte address width of cache and memory requests
- BLOCK_W, 128, cache line width in bits (one transfer moves one full line)

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  I-cache miss request; held high until i_done seen
- i_addr  in  ADDR_W  I-cache line address
- i_rdata  out  BLOCK_W  registered line returned to I-cache
- i_done  out  1  one-cycle completion pulse to I-cache
- d_req  in  1  D-cache request; held high until d_done seen
- d_we  in  1  1 = write-back of d_wdata, 0 = refill read
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  BLOCK_W  dirty line to write back
- d_rdata  out  BLOCK_W  registered line returned to D-cache
- d_done  out  1  one-cycle completion pulse to D-cache
- mem_req  out  1  memory transaction active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  BLOCK_W  memory write data
- mem_rdata  in  BLOCK_W  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory completes current transaction this cycle
- busy  out  1  state != IDLE
- owner_d  out  1  current or most recent grant (1 = D, 0 = I)

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - Only i_req -> BUSY_I.
  - Only d_req -> BUSY_D.
  - Both -> grant the port opposite to owner_d.
  - Neither -> stay.
- At grant, latch the winner's addr, plus we and wdata for D, into internal registers. Request inputs are ignored after the grant cycle until the next IDLE.
- BUSY_x:
  - mem_req=1; mem_addr/mem_we/mem_wdata come from the latched registers.
  - mem_we=0 always for I.
  - On mem_ready=1:
    - Read: capture mem_rdata into x_rdata.
    - Write: leave d_rdata unchanged.
    - Go to RESP.
- RESP: x_done=1 for exactly this cycle, no grant evaluated, then -> IDLE. The requester drops req in the cycle it sees done, so it is never re-granted by a stale req.
- Outside BUSY_x:
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - mem_ready is ignored.
- owner_d updates only at grant.
- i_rdata/d_rdata hold their value until the next read completion for that port.
- Reset (any state, including mid-transaction):
  - state=IDLE; owner_d=0; mem_req/mem_we=0; mem_addr/mem_wdata=0; i_done/d_done=0; i_rdata/d_rdata=0; busy=0.
  - Any in-flight memory transaction is abandoned; a late mem_ready after reset is ignored.
- Because owner_d resets to 0, the first simultaneous request goes to D.

## Timing
- Request sampled in IDLE at cycle t -> BUSY at t+1; mem_req high from t+1.
- mem_ready at cycle r (r >= t+1) -> RESP at r+1 with x_done=1 and x_rdata valid -> IDLE at r+2.
- Minimum request-to-done latency: 2 cycles (mem_ready in t+1).
- Back-to-back: a request pending at r+2 is granted at r+2, with mem_req at r+3. Minimum gap between transactions is 2 idle memory cycles (RESP, IDLE).
- mem_req stays high continuously from grant+1 through the mem_ready cycle; mem_addr/mem_wdata are stable throughout.
- i_done and d_done are never high in the same cycle.
- busy is high in BUSY_I, BUSY_D and RESP.

## Test plan
- Reset release, no requests -> all outputs 0 and busy=0 for 10 cycles; mem_ready pulsed while idle changes nothing.
- i_req=1, i_addr=0x0000_1040 at t; memory answers mem_ready at t+3 with mem_rdata=0xA5..A5 -> mem_req high t+1..t+3, mem_addr=0x1040, mem_we=0; i_done only at t+4; i_rdata=0xA5..A5.
- d_req=1, d_we=1, d_addr=0x2000, d_wdata=0x1234..; mem_ready in first BUSY cycle -> mem_we=1, mem_wdata matches; d_done at t+2; d_rdata unchanged.
- i_req and d_req both high from reset, each re-raised right after its done -> grants alternate D, I, D, I; owner_d toggles each grant; no cycle has both done pulses.
- d_addr changed to 0xFFFF_FFC0 during BUSY_D -> mem_addr keeps the latched value; reset asserted mid-BUSY_D, then mem_ready arrives -> no d_done, state IDLE, outputs at reset values.
